// File: rtl/ecc_pkg.sv
// Shared helpers for the Hamming+overall-parity SECDED code: parity width and
// the data-bit-to-codeword-position map used by both encoder and decoder.
package ecc_pkg;

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Smallest p with 2^p >= data_width + p + 1; scanned downward so the last hit wins.
  function automatic int calc_par_width(input int data_width);
    int r;
    r = 0;
    for (int p = 30; p >= 1; p--) begin
      if ((1 << p) >= data_width + p + 1) r = p;
    end
    return r;
  endfunction

  // Data bit i skips every power-of-2 position at or below where it lands.
  function automatic int data_pos(input int i);
    int pos;
    pos = i + 1;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) <= pos) pos++;
    end
    return pos;
  endfunction

endpackage

// File: rtl/ecc_par_gen.sv
// Combinational Hamming parity generator; parity k covers every data bit whose
// codeword position has bit k set.
module ecc_par_gen
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  localparam int PAR_WIDTH = calc_par_width(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [PAR_WIDTH-1:0]  par
);

  function automatic logic [DATA_WIDTH-1:0] par_mask(input int k);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      m[i] = ((data_pos(i) >> k) & 1) != 0;
    end
    return m;
  endfunction

  for (genvar k = 0; k < PAR_WIDTH; k++) begin : g_par
    localparam logic [DATA_WIDTH-1:0] MASK = par_mask(k);
    assign par[k] = ^(data & MASK);
  end

endmodule

// File: rtl/ecc_secded_dec_pipe.sv
// Two-stage SECDED checker/corrector: stage 1 computes syndrome and overall
// check, stage 2 classifies/corrects into the output register; saturating CE/UE counters.
module ecc_secded_dec_pipe
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16,
  localparam int PAR_WIDTH = calc_par_width(DATA_WIDTH),
  localparam int ECC_WIDTH = PAR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ECC_WIDTH-1:0]  in_ecc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_ce,
  output logic                  out_ue,
  output logic [PAR_WIDTH-1:0]  out_syndrome,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  ce_cnt,
  output logic [CNT_WIDTH-1:0]  ue_cnt
);

  logic [PAR_WIDTH-1:0]  par_calc;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [PAR_WIDTH-1:0]  s1_syn_q, s1_syn_d;
  logic                  s1_ovr_q, s1_ovr_d;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_ce_q, out_ce_d;
  logic                  out_ue_q, out_ue_d;
  logic [PAR_WIDTH-1:0]  out_syn_q, out_syn_d;

  logic [CNT_WIDTH-1:0]  ce_cnt_q, ce_cnt_d;
  logic [CNT_WIDTH-1:0]  ue_cnt_q, ue_cnt_d;

  logic [DATA_WIDTH-1:0] flip_vec;
  logic [DATA_WIDTH-1:0] cls_data;
  logic                  syn_zero, syn_pow2, syn_data, cls_ce, cls_ue;
  logic                  s2_free, s1_free, accept;

  ecc_par_gen #(.DATA_WIDTH(DATA_WIDTH)) u_par_gen (
    .data (in_data),
    .par  (par_calc)
  );

  // One-hot of the data bit sitting at the syndrome position (all zero otherwise).
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_flip
    localparam int POS = data_pos(i);
    assign flip_vec[i] = (int'(s1_syn_q) == POS);
  end

  always_comb begin
    syn_zero = (s1_syn_q == '0);
    syn_pow2 = is_pow2(int'(s1_syn_q));
    syn_data = |flip_vec;
    cls_ce   = s1_ovr_q & (syn_zero | syn_pow2 | syn_data);
    cls_ue   = !syn_zero & (!s1_ovr_q | (!syn_pow2 & !syn_data));
    cls_data = s1_data_q ^ (flip_vec & {DATA_WIDTH{s1_ovr_q}});
  end

  always_comb begin
    s2_free = !out_valid_q | out_ready;
    s1_free = !s1_valid_q | s2_free;
    accept  = out_valid_q & out_ready;

    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_syn_d    = s1_syn_q;
    s1_ovr_d    = s1_ovr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ce_d    = out_ce_q;
    out_ue_d    = out_ue_q;
    out_syn_d   = out_syn_q;
    ce_cnt_d    = ce_cnt_q;
    ue_cnt_d    = ue_cnt_q;

    if (s1_free) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_syn_d  = par_calc ^ in_ecc[PAR_WIDTH-1:0];
        s1_ovr_d  = (^in_data) ^ (^in_ecc);
      end
    end

    if (s2_free) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = cls_ue ? s1_data_q : cls_data;
        out_ce_d   = cls_ce;
        out_ue_d   = cls_ue;
        out_syn_d  = s1_syn_q;
      end
    end

    if (cnt_clr) begin
      ce_cnt_d = '0;
      ue_cnt_d = '0;
    end else begin
      if (accept && out_ce_q && !(&ce_cnt_q)) ce_cnt_d = ce_cnt_q + CNT_WIDTH'(1);
      if (accept && out_ue_q && !(&ue_cnt_q)) ue_cnt_d = ue_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_syn_q    <= '0;
      s1_ovr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ce_q    <= 1'b0;
      out_ue_q    <= 1'b0;
      out_syn_q   <= '0;
      ce_cnt_q    <= '0;
      ue_cnt_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_syn_q    <= s1_syn_d;
      s1_ovr_q    <= s1_ovr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ce_q    <= out_ce_d;
      out_ue_q    <= out_ue_d;
      out_syn_q   <= out_syn_d;
      ce_cnt_q    <= ce_cnt_d;
      ue_cnt_q    <= ue_cnt_d;
    end
  end

  assign in_ready     = s1_free;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_ce       = out_ce_q;
  assign out_ue       = out_ue_q;
  assign out_syndrome = out_syn_q;
  assign ce_cnt       = ce_cnt_q;
  assign ue_cnt       = ue_cnt_q;

endmodule
